// File: rtl/alu_op_sequencer_pkg.sv
// Shared constants for the ALU-op sequencer: widened ALU op codes, RISC-V opcode/funct
// fields and the sequencer state encoding.
package alu_op_sequencer_pkg;

    localparam logic [4:0] ALU_OP_ADD    = 5'h00;
    localparam logic [4:0] ALU_OP_SUB    = 5'h01;
    localparam logic [4:0] ALU_OP_SLL    = 5'h02;
    localparam logic [4:0] ALU_OP_SLT    = 5'h03;
    localparam logic [4:0] ALU_OP_SLTU   = 5'h04;
    localparam logic [4:0] ALU_OP_XOR    = 5'h05;
    localparam logic [4:0] ALU_OP_SRL    = 5'h06;
    localparam logic [4:0] ALU_OP_SRA    = 5'h07;
    localparam logic [4:0] ALU_OP_OR     = 5'h08;
    localparam logic [4:0] ALU_OP_AND    = 5'h09;
    localparam logic [4:0] ALU_OP_BPA    = 5'h0A;
    localparam logic [4:0] ALU_OP_ABJ    = 5'h0B;
    localparam logic [4:0] ALU_OP_NOP    = 5'h0F;
    localparam logic [4:0] ALU_OP_MUL    = 5'h10;
    localparam logic [4:0] ALU_OP_MULH   = 5'h11;
    localparam logic [4:0] ALU_OP_MULHSU = 5'h12;
    localparam logic [4:0] ALU_OP_MULHU  = 5'h13;
    localparam logic [4:0] ALU_OP_DIV    = 5'h14;
    localparam logic [4:0] ALU_OP_DIVU   = 5'h15;
    localparam logic [4:0] ALU_OP_REM    = 5'h16;
    localparam logic [4:0] ALU_OP_REMU   = 5'h17;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StHold = 2'd2;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I/RV32M opcode/funct decode into the widened ALU op code.
module alu_op_decode
    import alu_op_sequencer_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output logic [4:0] alu_op_o,
    output logic       is_m_o,
    output logic       is_div_o,
    output logic       illegal_o
);

    // funct3-indexed ops shared by OP-IMM and OP; sra_sel picks SRA for funct3=101.
    function automatic logic [4:0] op_by_funct3(input logic [2:0] f3, input logic sra_sel);
        case (f3)
            3'b000:  return ALU_OP_ADD;
            3'b001:  return ALU_OP_SLL;
            3'b010:  return ALU_OP_SLT;
            3'b011:  return ALU_OP_SLTU;
            3'b100:  return ALU_OP_XOR;
            3'b101:  return sra_sel ? ALU_OP_SRA : ALU_OP_SRL;
            3'b110:  return ALU_OP_OR;
            default: return ALU_OP_AND;
        endcase
    endfunction

    always_comb begin
        alu_op_o  = ALU_OP_NOP;
        is_m_o    = 1'b0;
        is_div_o  = 1'b0;
        illegal_o = 1'b0;
        case (opcode_i)
            OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_STORE: alu_op_o = ALU_OP_ADD;
            OPC_BRANCH: begin
                case (funct3_i[2:1])
                    2'b00:   alu_op_o = ALU_OP_SUB;
                    2'b10:   alu_op_o = ALU_OP_SLT;
                    2'b11:   alu_op_o = ALU_OP_SLTU;
                    default: illegal_o = 1'b1;
                endcase
            end
            OPC_OP_IMM: alu_op_o = op_by_funct3(funct3_i, funct7_i[5]);
            OPC_OP: begin
                if (funct7_i == FUNCT7_BASE) begin
                    alu_op_o = op_by_funct3(funct3_i, 1'b0);
                end else if (funct7_i == FUNCT7_ALT && funct3_i == 3'b000) begin
                    alu_op_o = ALU_OP_SUB;
                end else if (funct7_i == FUNCT7_ALT && funct3_i == 3'b101) begin
                    alu_op_o = ALU_OP_SRA;
                end else if (funct7_i == FUNCT7_MULDIV && ENABLE_M) begin
                    alu_op_o = ALU_OP_MUL | {2'b00, funct3_i};
                    is_m_o   = 1'b1;
                    is_div_o = funct3_i[2];
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OPC_SYSTEM: begin
                case (funct3_i[1:0])
                    2'b01:   alu_op_o = ALU_OP_BPA;
                    2'b10:   alu_op_o = ALU_OP_OR;
                    2'b11:   alu_op_o = ALU_OP_ABJ;
                    default: illegal_o = 1'b1;
                endcase
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Registered valid/ready ALU-op sequencer; M-extension ops are held for a fixed latency
// before their result is presented to execute.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int unsigned ALU_OP_W   = 5,
    parameter bit          ENABLE_M   = 1'b1,
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 33
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic [6:0]          funct7,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                multi_cycle,
    output logic                illegal,
    output logic                md_start,
    output logic                busy
);

    localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles);
    localparam logic [CntW-1:0] MulLoad = CntW'(MUL_CYCLES - 2);
    localparam logic [CntW-1:0] DivLoad = CntW'(DIV_CYCLES - 2);

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [4:0]      op_q, op_d;
    logic            mc_q, mc_d;
    logic            ill_q, ill_d;
    logic            md_start_q, md_start_d;

    logic [4:0] dec_op;
    logic       dec_is_m, dec_is_div, dec_illegal;
    logic       accept;

    alu_op_decode #(
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .opcode_i  (opcode),
        .funct3_i  (funct3),
        .funct7_i  (funct7),
        .alu_op_o  (dec_op),
        .is_m_o    (dec_is_m),
        .is_div_o  (dec_is_div),
        .illegal_o (dec_illegal)
    );

    assign in_ready = !flush && ((state_q == StIdle) || (state_q == StHold && out_ready));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        mc_d       = mc_q;
        ill_d      = ill_q;
        md_start_d = 1'b0;
        if (flush) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else if (accept) begin
            op_d  = dec_op;
            mc_d  = dec_is_m;
            ill_d = dec_illegal;
            if (dec_is_m) begin
                state_d    = StWait;
                cnt_d      = dec_is_div ? DivLoad : MulLoad;
                md_start_d = 1'b1;
            end else begin
                state_d = StHold;
            end
        end else begin
            case (state_q)
                StWait: begin
                    if (cnt_q == '0) begin
                        state_d = StHold;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        state_d = StIdle;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            op_q       <= ALU_OP_NOP;
            mc_q       <= 1'b0;
            ill_q      <= 1'b0;
            md_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            mc_q       <= mc_d;
            ill_q      <= ill_d;
            md_start_q <= md_start_d;
        end
    end

    assign out_valid   = (state_q == StHold);
    assign busy        = (state_q == StWait);
    assign alu_op      = ALU_OP_W'(op_q);
    assign multi_cycle = mc_q;
    assign illegal     = ill_q;
    assign md_start    = md_start_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed scenarios plus randomized ops
// compared against a behavioural decode/latency model.
module tb_alu_op_sequencer;
    import alu_op_sequencer_pkg::*;

    localparam int unsigned MulN = 4;
    localparam int unsigned DivN = 33;

    logic       clk = 1'b0;
    logic       reset_n, flush, in_valid, nm_in_valid, out_ready;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic       in_ready, out_valid, multi_cycle, illegal, md_start, busy;
    logic [4:0] alu_op;
    logic       nm_in_ready, nm_out_valid, nm_multi_cycle, nm_illegal, nm_md_start, nm_busy;
    logic [4:0] nm_alu_op;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(
        .ALU_OP_W   (5),
        .ENABLE_M   (1'b1),
        .MUL_CYCLES (MulN),
        .DIV_CYCLES (DivN)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7      (funct7),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_op      (alu_op),
        .multi_cycle (multi_cycle),
        .illegal     (illegal),
        .md_start    (md_start),
        .busy        (busy)
    );

    alu_op_sequencer #(
        .ALU_OP_W   (5),
        .ENABLE_M   (1'b0),
        .MUL_CYCLES (MulN),
        .DIV_CYCLES (DivN)
    ) dut_nm (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .in_valid    (nm_in_valid),
        .in_ready    (nm_in_ready),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7      (funct7),
        .out_valid   (nm_out_valid),
        .out_ready   (out_ready),
        .alu_op      (nm_alu_op),
        .multi_cycle (nm_multi_cycle),
        .illegal     (nm_illegal),
        .md_start    (nm_md_start),
        .busy        (nm_busy)
    );

    typedef struct packed {
        logic [4:0] op;
        logic       m;
        logic       div;
        logic       ill;
    } exp_t;

    // Reference decode written straight from the instruction-set tables.
    function automatic exp_t model(input logic [6:0] opc, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic en_m);
        logic [4:0] tbl [8];
        exp_t r;
        tbl = '{ALU_OP_ADD, ALU_OP_SLL, ALU_OP_SLT, ALU_OP_SLTU,
                ALU_OP_XOR, ALU_OP_SRL, ALU_OP_OR, ALU_OP_AND};
        r = '{op: ALU_OP_NOP, m: 1'b0, div: 1'b0, ill: 1'b1};
        if (opc == 7'b0010111 || opc == 7'b1101111 || opc == 7'b1100111 ||
            opc == 7'b0000011 || opc == 7'b0100011) begin
            r = '{op: ALU_OP_ADD, m: 1'b0, div: 1'b0, ill: 1'b0};
        end else if (opc == 7'b1100011) begin
            if (f3 == 3'd0 || f3 == 3'd1) r = '{op: ALU_OP_SUB, m: 1'b0, div: 1'b0, ill: 1'b0};
            if (f3 == 3'd4 || f3 == 3'd5) r = '{op: ALU_OP_SLT, m: 1'b0, div: 1'b0, ill: 1'b0};
            if (f3 == 3'd6 || f3 == 3'd7) r = '{op: ALU_OP_SLTU, m: 1'b0, div: 1'b0, ill: 1'b0};
        end else if (opc == 7'b0010011) begin
            r = '{op: tbl[f3], m: 1'b0, div: 1'b0, ill: 1'b0};
            if (f3 == 3'd5 && f7[5]) r.op = ALU_OP_SRA;
        end else if (opc == 7'b0110011) begin
            if (f7 == 7'd0) r = '{op: tbl[f3], m: 1'b0, div: 1'b0, ill: 1'b0};
            if (f7 == 7'h20 && f3 == 3'd0) r = '{op: ALU_OP_SUB, m: 1'b0, div: 1'b0, ill: 1'b0};
            if (f7 == 7'h20 && f3 == 3'd5) r = '{op: ALU_OP_SRA, m: 1'b0, div: 1'b0, ill: 1'b0};
            if (f7 == 7'h01 && en_m)
                r = '{op: 5'(16 + int'(f3)), m: 1'b1, div: (f3 >= 3'd4), ill: 1'b0};
        end else if (opc == 7'b1110011) begin
            if (f3 == 3'd1 || f3 == 3'd5) r = '{op: ALU_OP_BPA, m: 1'b0, div: 1'b0, ill: 1'b0};
            if (f3 == 3'd2 || f3 == 3'd6) r = '{op: ALU_OP_OR, m: 1'b0, div: 1'b0, ill: 1'b0};
            if (f3 == 3'd3 || f3 == 3'd7) r = '{op: ALU_OP_ABJ, m: 1'b0, div: 1'b0, ill: 1'b0};
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op on the ENABLE_M=1 instance and follow it to completion.
    task automatic run_op(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                          input int stall);
        exp_t e;
        int   n, lat, nbusy, extra, exp_lat;
        e = model(opc, f3, f7, 1'b1);
        exp_lat = e.m ? (e.div ? int'(DivN) - 1 : int'(MulN) - 1) : 0;
        out_ready = 1'b0;
        opcode = opc; funct3 = f3; funct7 = f7; in_valid = 1'b1;
        #1;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk); #1; n++;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("md_start_first", 32'(md_start), 32'(e.m));
        lat = 0; extra = 0;
        nbusy = (busy === 1'b1) ? 1 : 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
            if (md_start !== 1'b0) extra++;
            if (busy === 1'b1) nbusy++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("busy_cycles", 32'(nbusy), 32'(exp_lat));
        check("md_start_extra", 32'(extra), 32'd0);
        check("alu_op", 32'(alu_op), 32'(e.op));
        check("multi_cycle", 32'(multi_cycle), 32'(e.m));
        check("illegal", 32'(illegal), 32'(e.ill));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_op", 32'(alu_op), 32'(e.op));
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("drain_idle", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] opc_tbl [10];
        logic [6:0] r_opc, r_f7;
        logic [2:0] r_f3;
        int         sel;
        opc_tbl = '{OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_STORE,
                    OPC_BRANCH, OPC_OP_IMM, OPC_OP, OPC_OP, OPC_SYSTEM};

        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; nm_in_valid = 1'b0;
        out_ready = 1'b0; opcode = '0; funct3 = '0; funct7 = '0;

        // Reset values
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'(ALU_OP_NOP));
        check("rst_flags", 32'({illegal, multi_cycle, md_start, busy}), 32'd0);
        reset_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // ADDI back-to-back with out_ready held high
        @(negedge clk);
        out_ready = 1'b1;
        opcode = OPC_OP_IMM; funct3 = 3'd0; funct7 = 7'd0; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("b2b_in_ready", 32'(in_ready), 32'd1);
            @(negedge clk);
            check("b2b_out_valid", 32'(out_valid), 32'd1);
            check("b2b_alu_op", 32'(alu_op), 32'(ALU_OP_ADD));
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_idle", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // DIV, full latency
        run_op(OPC_OP, 3'b100, FUNCT7_MULDIV, 0);
        check("div_code", 32'(alu_op), 32'h14);

        // MUL with the M extension disabled
        opcode = OPC_OP; funct3 = 3'b000; funct7 = FUNCT7_MULDIV;
        out_ready = 1'b1; nm_in_valid = 1'b1;
        #1;
        check("nm_in_ready", 32'(nm_in_ready), 32'd1);
        @(negedge clk);
        nm_in_valid = 1'b0;
        check("nm_out_valid", 32'(nm_out_valid), 32'd1);
        check("nm_illegal", 32'(nm_illegal), 32'd1);
        check("nm_alu_op", 32'(nm_alu_op), 32'(ALU_OP_NOP));
        check("nm_md_start", 32'({nm_md_start, nm_busy, nm_multi_cycle}), 32'd0);
        @(negedge clk);
        check("nm_idle", 32'(nm_out_valid), 32'd0);
        out_ready = 1'b0;

        // SRAI held under backpressure; a waiting ADDI must not be taken
        opcode = OPC_OP_IMM; funct3 = 3'b101; funct7 = 7'b0100000; in_valid = 1'b1;
        #1;
        check("srai_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        funct3 = 3'd0; funct7 = 7'd0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_alu_op", 32'(alu_op), 32'(ALU_OP_SRA));
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("release_next_op", 32'(alu_op), 32'(ALU_OP_ADD));
        check("release_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        check("release_idle", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // MULHU killed by flush two cycles after accept
        opcode = OPC_OP; funct3 = 3'b011; funct7 = FUNCT7_MULDIV; in_valid = 1'b1;
        #1;
        @(negedge clk);
        in_valid = 1'b0;
        check("flush_md_start", 32'(md_start), 32'd1);
        check("flush_busy", 32'(busy), 32'd1);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; funct7 = 7'd0; opcode = OPC_OP_IMM; funct3 = 3'd0;
        #1;
        check("flush_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("flush_idle_busy", 32'(busy), 32'd0);
        check("flush_idle_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("flush_no_valid", 32'({out_valid, md_start}), 32'd0);
        end

        // Asynchronous reset during WAIT, then BEQ
        opcode = OPC_OP; funct3 = 3'b100; funct7 = FUNCT7_MULDIV; in_valid = 1'b1;
        #1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("async_rst_flags", 32'({out_valid, illegal, multi_cycle, md_start, busy}), 32'd0);
        check("async_rst_alu_op", 32'(alu_op), 32'(ALU_OP_NOP));
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("post_rst_ready", 32'(in_ready), 32'd1);
        run_op(OPC_BRANCH, 3'b000, 7'd0, 1);
        check("beq_sub", 32'(alu_op), 32'(ALU_OP_SUB));

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 10));
            r_opc = (sel == 10) ? 7'($urandom) : opc_tbl[sel];
            r_f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       r_f7 = 7'd0;
                1:       r_f7 = 7'h20;
                2:       r_f7 = FUNCT7_MULDIV;
                default: r_f7 = 7'($urandom);
            endcase
            run_op(r_opc, r_f3, r_f7, int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
